branch_target_unit: RTL

BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

---
 rtl/mips_pkg.sv | 16 +
 rtl/bt_pipe_slice.sv | 35 +++
 rtl/branch_target_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the branch target path.
// Mode encodings and default datapath geometry.
package mips_pkg;

   localparam int DefWidth  = 32;
   localparam int DefShift  = 2;
   localparam int DefJField = 26;

   typedef enum logic [1:0] {
      ModeRel  = 2'b00,
      ModeJump = 2'b01,
      ModeReg  = 2'b10,
      ModeFall = 2'b11
   } btMode_t;

endpackage

// File: rtl/bt_pipe_slice.sv
// Valid/ready register slice with hold and flush.
// Holds its contents while the downstream stalls.
module bt_pipe_slice #(
   parameter int DW = 8
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          Flush,
   input  logic          InValid,
   output logic          InReady,
   input  logic [DW-1:0] InData,
   output logic          OutValid,
   input  logic          OutReady,
   output logic [DW-1:0] OutData
);

   logic advance;

   assign advance = ~OutValid | OutReady;
   assign InReady = Rst_n & ~Flush & advance;

   // Slice register: flush empties, otherwise load when free or draining.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         OutValid <= 1'b0;
         OutData  <= '0;
      end else if (Flush) begin
         OutValid <= 1'b0;
      end else if (advance) begin
         OutValid <= InValid;
         if (InValid) OutData <= InData;
      end
   end

endmodule

// File: rtl/branch_target_unit.sv
// Branch/jump target computation with 1 or 2
// pipeline stages and valid/ready handshakes.
module branch_target_unit
   import mips_pkg::*;
#(
   parameter int WIDTH  = DefWidth,
   parameter int SHIFT  = DefShift,
   parameter int JFIELD = DefJField,
   parameter int STAGES = 1
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [1:0]       Mode,
   input  logic [WIDTH-1:0] PCPlus4,
   input  logic [WIDTH-1:0] Offset,
   input  logic [WIDTH-1:0] RegTarget,
   input  logic             Flush,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Target,
   output logic             Overflow,
   output logic             Misaligned
);

   localparam logic [WIDTH-1:0] Ones = '1;
   localparam logic [WIDTH-1:0] AlignMask = ~(Ones << SHIFT);
   localparam logic [WIDTH-1:0] JMask = ~(Ones << JFIELD);
   localparam logic [WIDTH-1:0] HiMask = Ones << (JFIELD + SHIFT);
   localparam int LoW = WIDTH / 2;
   localparam int HiW = WIDTH - LoW;

   btMode_t          mode;
   logic             isRel;
   logic             isJump;
   logic             isReg;
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] altTarget;

   assign mode   = btMode_t'(Mode);
   assign isRel  = (mode == ModeRel);
   assign isJump = (mode == ModeJump);
   assign isReg  = (mode == ModeReg);
   assign addend = Offset << SHIFT;

   // Targets that need no adder: jump splice, register, fall-through.
   always_comb begin
      altTarget = PCPlus4;
      unique case (1'b1)
         isJump:  altTarget = (PCPlus4 & HiMask)
                            | ((Offset & JMask) << SHIFT);
         isReg:   altTarget = RegTarget;
         default: altTarget = PCPlus4;
      endcase
   end

   if (STAGES == 1) begin : gSingle

      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] tgt;
      logic             ovf;
      logic             mis;

      // Full-width add, select and flags in one cycle.
      always_comb begin
         sum = PCPlus4 + addend;
         tgt = isRel ? sum : altTarget;
         ovf = isRel
             & (PCPlus4[WIDTH-1] == addend[WIDTH-1])
             & (sum[WIDTH-1] != PCPlus4[WIDTH-1]);
         mis = |(tgt & AlignMask);
      end

      bt_pipe_slice #(.DW(WIDTH + 2)) uSlice0 (
         .Clk      (Clk),
         .Rst_n    (Rst_n),
         .Flush    (Flush),
         .InValid  (InValid),
         .InReady  (InReady),
         .InData   ({tgt, ovf, mis}),
         .OutValid (OutValid),
         .OutReady (OutReady),
         .OutData  ({Target, Overflow, Misaligned})
      );

   end else begin : gDouble

      localparam int S1W = 2 + LoW + 2 * HiW + WIDTH;

      logic             c1;
      logic [LoW-1:0]   lo1;
      logic [S1W-1:0]   s1In;
      logic [S1W-1:0]   s1Out;
      logic             s1Valid;
      logic             s2Ready;
      logic             rRel;
      logic             rCarry;
      logic [LoW-1:0]   rLo;
      logic [HiW-1:0]   rPcHi;
      logic [HiW-1:0]   rAddHi;
      logic [WIDTH-1:0] rAlt;
      logic [HiW-1:0]   hi2;
      logic [WIDTH-1:0] tgt;
      logic             ovf;
      logic             mis;

      // Low half add; carry travels with the request.
      always_comb begin
         {c1, lo1} = {1'b0, PCPlus4[LoW-1:0]}
                   + {1'b0, addend[LoW-1:0]};
         s1In = {isRel, c1, lo1,
                 PCPlus4[WIDTH-1:LoW],
                 addend[WIDTH-1:LoW],
                 altTarget};
      end

      bt_pipe_slice #(.DW(S1W)) uSlice0 (
         .Clk      (Clk),
         .Rst_n    (Rst_n),
         .Flush    (Flush),
         .InValid  (InValid),
         .InReady  (InReady),
         .InData   (s1In),
         .OutValid (s1Valid),
         .OutReady (s2Ready),
         .OutData  (s1Out)
      );

      assign {rRel, rCarry, rLo, rPcHi, rAddHi, rAlt} = s1Out;

      // High half add with registered carry, then select and flags.
      always_comb begin
         hi2 = rPcHi + rAddHi + {{(HiW-1){1'b0}}, rCarry};
         tgt = rRel ? {hi2, rLo} : rAlt;
         ovf = rRel
             & (rPcHi[HiW-1] == rAddHi[HiW-1])
             & (hi2[HiW-1] != rPcHi[HiW-1]);
         mis = |(tgt & AlignMask);
      end

      bt_pipe_slice #(.DW(WIDTH + 2)) uSlice1 (
         .Clk      (Clk),
         .Rst_n    (Rst_n),
         .Flush    (Flush),
         .InValid  (s1Valid),
         .InReady  (s2Ready),
         .InData   ({tgt, ovf, mis}),
         .OutValid (OutValid),
         .OutReady (OutReady),
         .OutData  ({Target, Overflow, Misaligned})
      );

   end

endmodule
